// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch predictor.
//   lc3b_word   : 16-bit machine word (PC, instruction, target)
//   lc3b_ctr2   : 2-bit saturating counter state
//   OP_BR       : BR opcode in ir[15:12]
//   br_target() : PC-relative branch target, pc + 2 + (sext(off9) << 1)
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_ctr2;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode OP_BR       = 4'b0000;
  // Reset value of every counter: weakly not-taken / weakly local.
  localparam lc3b_ctr2   CTR_WEAK_LO = 2'b01;

  // The addition wraps modulo 2^16.
  function automatic lc3b_word br_target(input lc3b_word pc, input logic [8:0] off9);
    lc3b_word offset;
    offset = {{6{off9[8]}}, off9, 1'b0};
    return pc + 16'd2 + offset;
  endfunction

endpackage

// File: rtl/br_predictor_if.sv
// Fetch/resolve interface of the tournament branch predictor.
//   Lookup side : pc, ir in; br_pr, target, pred, local_index, global_index out.
//   Update side : upd_valid, upd_taken, upd_pred, upd_local_index,
//                 upd_global_index in (values carried down the pipe).
// master = pipeline driving the predictor, slave = the predictor itself.
interface br_predictor_if #(
  parameter int LS = 8,
  parameter int GS = 6
);
  import lc3b_types::*;

  lc3b_word          pc;
  lc3b_word          ir;
  logic              br_pr;
  lc3b_word          target;
  logic [1:0]        pred;
  logic [LS-1:0]     local_index;
  logic [GS-1:0]     global_index;

  logic              upd_valid;
  logic              upd_taken;
  logic [1:0]        upd_pred;
  logic [LS-1:0]     upd_local_index;
  logic [GS-1:0]     upd_global_index;

  modport master (
    output pc, ir, upd_valid, upd_taken, upd_pred, upd_local_index, upd_global_index,
    input  br_pr, target, pred, local_index, global_index
  );

  modport slave (
    input  pc, ir, upd_valid, upd_taken, upd_pred, upd_local_index, upd_global_index,
    output br_pr, target, pred, local_index, global_index
  );

endinterface

// File: rtl/sat_ctr2.sv
// 2-bit saturating up/down counter, next-state only (no storage).
//   ctr      : current counter value
//   inc      : 1 = count up (saturate at 11), 0 = count down (saturate at 00)
//   ctr_next : next counter value
module sat_ctr2
  import lc3b_types::*;
(
  input  lc3b_ctr2 ctr,
  input  logic     inc,
  output lc3b_ctr2 ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/br_predictor.sv
// Tournament branch predictor for the LC-3b fetch stage.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : br_predictor_if slave port (lookup + resolve/update)
// Lookup is purely combinational from pc/ir and the current table state.
// A local table (indexed by pc), a gshare-style global table (ghr ^ pc) and
// a chooser (indexed like the local table) are updated at branch resolution
// from the indices and predictions carried down the pipe.
module br_predictor
  import lc3b_types::*;
#(
  parameter int LS = 8,
  parameter int GS = 6
) (
  input  logic            clk,
  input  logic            reset,
  br_predictor_if.slave   bus
);

  localparam int LN = 1 << LS;
  localparam int GN = 1 << GS;

  lc3b_ctr2        local_q   [LN];
  lc3b_ctr2        global_q  [GN];
  lc3b_ctr2        chooser_q [LN];
  logic [GS-1:0]   ghr_q;
  logic [GS-1:0]   ghr_d;

  // ---------------------------------------------------------------- lookup
  logic            is_br;
  logic [LS-1:0]   lk_local_index;
  logic [GS-1:0]   lk_global_index;
  logic [1:0]      lk_pred;
  logic            use_global;
  logic            lk_br_pr;

  always_comb begin
    is_br           = (bus.ir[15:12] == OP_BR) && (bus.ir[11:9] != 3'b000);
    lk_local_index  = bus.pc[LS:1];
    lk_global_index = ghr_q ^ bus.pc[GS:1];
    lk_pred         = {local_q[lk_local_index][1], global_q[lk_global_index][1]};
    use_global      = chooser_q[lk_local_index][1];
    lk_br_pr        = is_br & (use_global ? lk_pred[0] : lk_pred[1]);
  end

  assign bus.br_pr        = lk_br_pr;
  assign bus.pred         = lk_pred;
  assign bus.local_index  = lk_local_index;
  assign bus.global_index = lk_global_index;
  assign bus.target       = br_target(bus.pc, bus.ir[8:0]);

  // ---------------------------------------------------------------- update
  lc3b_ctr2 local_cur,   local_d;
  lc3b_ctr2 global_cur,  global_d;
  lc3b_ctr2 chooser_cur, chooser_nxt, chooser_d;
  logic     chooser_inc;

  assign local_cur   = local_q[bus.upd_local_index];
  assign global_cur  = global_q[bus.upd_global_index];
  assign chooser_cur = chooser_q[bus.upd_local_index];

  // Chooser moves toward global when the global component was the one right.
  assign chooser_inc = (bus.upd_pred[0] == bus.upd_taken);

  sat_ctr2 u_local_ctr (
    .ctr      (local_cur),
    .inc      (bus.upd_taken),
    .ctr_next (local_d)
  );

  sat_ctr2 u_global_ctr (
    .ctr      (global_cur),
    .inc      (bus.upd_taken),
    .ctr_next (global_d)
  );

  sat_ctr2 u_chooser_ctr (
    .ctr      (chooser_cur),
    .inc      (chooser_inc),
    .ctr_next (chooser_nxt)
  );

  always_comb begin
    // Chooser only learns when the two components disagreed.
    chooser_d = (bus.upd_pred[1] ^ bus.upd_pred[0]) ? chooser_nxt : chooser_cur;
    ghr_d     = bus.upd_valid ? {ghr_q[GS-2:0], bus.upd_taken} : ghr_q;
  end

  // NOTE: the tables are reset entry-by-entry because the predictor must
  // come out of reset in a known weakly-biased state; this rules out a
  // RAM macro, which is acceptable at these table sizes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LN; i++) begin
        local_q[i]   <= CTR_WEAK_LO;
        chooser_q[i] <= CTR_WEAK_LO;
      end
      for (int i = 0; i < GN; i++) begin
        global_q[i]  <= CTR_WEAK_LO;
      end
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (bus.upd_valid) begin
        local_q[bus.upd_local_index]   <= local_d;
        global_q[bus.upd_global_index] <= global_d;
        chooser_q[bus.upd_local_index] <= chooser_d;
      end
    end
  end

endmodule

// File: doc/br_predictor.md
BR_PREDICTOR -- requirements
Module: br_predictor

Interface
REQ-001 Parameter LS, default 8, local-table index width (2^LS entries).
REQ-002 Parameter GS, default 6, global history width (2^GS entries).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 pc  input  16  fetch-stage PC of the instruction being fetched.
REQ-006 ir  input  16  fetched instruction word.
REQ-007 br_pr  output  1  predict-taken for this fetch.
REQ-008 target  output  16  predicted branch target.
REQ-009 pred  output  2  [1] = local-table prediction, [0] = global-table prediction.
REQ-010 local_index  output  LS  index used for the local and chooser tables.
REQ-011 global_index  output  GS  index used for the global table.
REQ-012 upd_valid  input  1  one resolved conditional branch this cycle.
REQ-013 upd_taken  input  1  resolved direction.
REQ-014 upd_pred  input  2  pred value that was carried down the pipe with the branch.
REQ-015 upd_local_index  input  LS  carried local_index.
REQ-016 upd_global_index  input  GS  carried global_index.

Function
REQ-017 Lookup SHALL be combinational, same cycle as pc/ir, with no registered output latency.
REQ-018 is_br SHALL be asserted iff ir[15:12]==0000 and ir[11:9]!=000.
REQ-019 local_index SHALL equal pc[LS:1].
REQ-020 global_index SHALL equal ghr XOR pc[GS:1].
REQ-021 pred[1] SHALL be local_table[local_index][1], and pred[0] SHALL be global_table[global_index][1].
REQ-022 chooser[local_index][1]==1 SHALL select pred[0]; otherwise pred[1] is selected.
REQ-023 br_pr SHALL be the selected prediction AND is_br; br_pr is 0 for non-branches, and pred/indices are still driven.
REQ-024 target SHALL equal pc + 2 + (sext(ir[8:0]) << 1), computed modulo 2^16 with wrap-around permitted.
REQ-025 On upd_valid, local_table[upd_local_index] SHALL increment when taken and decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-026 On upd_valid, global_table[upd_global_index] SHALL be updated with the same saturating rule.
REQ-027 On upd_valid with upd_pred[1]!=upd_pred[0], chooser[upd_local_index] SHALL move toward global (increment, saturating) if upd_pred[0]==upd_taken, otherwise toward local (decrement, saturating).
REQ-028 On upd_valid with upd_pred[1]==upd_pred[0], the chooser SHALL be left unchanged.
REQ-029 On upd_valid, ghr SHALL be updated to {ghr[GS-2:0], upd_taken}; ghr is updated non-speculatively, at resolution only.
REQ-030 When a lookup and an update hit the same entry in the same cycle, the lookup SHALL return the pre-update value, and the update SHALL take effect at the edge.
REQ-031 When upd_valid==0, no table or ghr state SHALL change.

Reset
REQ-032 While reset is high, every local and global counter SHALL be 2'b01 and every chooser SHALL be 2'b01 (weakly local), with ghr = 0, asynchronously.
REQ-033 Outputs SHALL derive combinationally from the reset state: br_pr = 0, and pred = 2'b00 for any pc/ir.
REQ-034 An update coinciding with reset SHALL be discarded.

Structure
REQ-035 lc3b_types SHALL hold lc3b_word and a 2-bit counter typedef (lc3b_ctr2), plus the LC3b BR opcode constant.
REQ-036 One sub-module sat_ctr2 (2-bit saturating increment/decrement, combinational) SHALL be instantiated for local, global and chooser updates.
REQ-037 Total RTL is 120-400 lines.

Verification
REQ-038 Reset, then pc=0x3000, ir=0x0E05 (BRnzp +5) -> br_pr=0, pred=00, local_index=0x00, target=0x300C.
REQ-039 Four updates taken at upd_local_index=0, upd_global_index=0, upd_pred=00 -> local[0]=11, ghr=001111; pc=0x3000 lookup gives pred[1]=1 and br_pr=1.
REQ-040 upd_pred=01 with taken=1, three times at chooser index 5 -> chooser[5] saturates at 11; a lookup with global[idx]=1x, local=0x gives br_pr=1.
REQ-041 ir=0x0000 (NOP BR) with strongly-taken entries -> br_pr=0.
REQ-042 pc=0xFFFE, ir=0x0E00 -> target=0x0000 (wrap); offset 0x100 at pc=0x0000 -> target=0xFE02.
REQ-043 Same-cycle lookup/update on entry 0 -> pre-update pred observed that cycle and updated value next cycle; assert reset mid-stream -> all state returns to reset values immediately.
